// File: rtl/sram_read_align.sv
// sram_read_align: byte-addressed SRAM read path with field alignment and a credit-guarded response FIFO
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      read request handshake; req_addr byte address, conf access width
//   sram_en/sram_addr        word read strobe and address to the 32-bit macro
//   sram_rdata               read word, valid one cycle after sram_en
//   rsp_valid/rsp_ready      response handshake; rsp_data zero-extended field, rsp_err illegal conf
module sram_read_align #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        conf,
    output logic              sram_en,
    output logic [ADDR_W-3:0] sram_addr,
    input  logic [31:0]       sram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic [OW:0]   used;
    logic          inflight, acc, push, pop;
    logic [1:0]    conf_q, off_q;
    logic [31:0]   aligned;
    logic [31:0]   data_mem [DEPTH];
    logic          err_mem  [DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // The in-flight read holds a credit, so a push always finds a free slot.
    assign used      = (OW+1)'(occ) + (OW+1)'(inflight);
    assign req_ready = !rst && used < (OW+1)'(DEPTH);
    assign acc       = req_valid && req_ready;
    assign sram_en   = acc;
    assign sram_addr = req_addr[ADDR_W-1:2];
    assign push      = inflight;
    assign rsp_valid = !rst && occ != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? data_mem[rd_ptr] : '0;
    assign rsp_err   = rsp_valid ? err_mem[rd_ptr] : 1'b0;

    always_comb begin
        aligned = conf_q == 2'b00 ? sram_rdata :
                  conf_q == 2'b01 ? {16'h0, off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0]} :
                  conf_q == 2'b10 ? {24'h0, sram_rdata[{off_q, 3'b000} +: 8]} : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= aligned;
            err_mem[wr_ptr]  <= conf_q == 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            conf_q   <= '0;
            off_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            inflight <= acc;
            if (acc) begin
                conf_q <= conf;
                off_q  <= req_addr[1:0];
            end
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            occ <= push && !pop ? occ + OW'(1) : !push && pop ? occ - OW'(1) : occ;
        end
    end
endmodule

// File: tb/tb_sram_read_align.sv
// tb_sram_read_align: directed self-checking bench for sram_read_align
module tb_sram_read_align;
    logic        clk = 0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [9:0]  req_addr;
    logic [1:0]  conf;
    logic        sram_en;
    logic [7:0]  sram_addr;
    logic [31:0] sram_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    logic [32:0] expq [$];

    sram_read_align #(.ADDR_W(10), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .conf(conf),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

    function automatic logic [31:0] pat(input int i);
        return 32'h1234_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response scoreboard: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (expq.size() == 0) check("stale_rsp", 32'(rsp_valid), 32'd0);
            else begin
                check("rsp_data", rsp_data, expq[0][31:0]);
                check("rsp_err", 32'(rsp_err), 32'(expq[0][32]));
                void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic [9:0] a, input logic [1:0] c, input logic [32:0] exp, output int stalls);
        stalls = 0;
        req_valid = 1; req_addr = a; conf = c;
        @(negedge clk);
        while (!req_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        else begin
            check("sram_en", 32'(sram_en), 32'd1);
            check("sram_addr", 32'(sram_addr), 32'(a[9:2]));
            expq.push_back(exp);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, tot;
        for (int i = 0; i < 256; i++) mem[i] = pat(i);
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'hA1B2C3D4;
        rst = 1; req_valid = 1; req_addr = 10'h10; conf = 0; rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sram_en", 32'(sram_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        send(10'h10, 2'b00, {1'b0, 32'hDEADBEEF}, st);
        @(negedge clk);
        check("lat_n1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_n2", 32'(rsp_valid), 32'd1);
        drain();

        send(10'h16, 2'b01, {1'b0, 32'h0000A1B2}, st);
        send(10'h14, 2'b01, {1'b0, 32'h0000C3D4}, st);
        send(10'h17, 2'b10, {1'b0, 32'h000000A1}, st);
        send(10'h15, 2'b10, {1'b0, 32'h000000C3}, st);
        send(10'h14, 2'b10, {1'b0, 32'h000000D4}, st);
        send(10'h17, 2'b00, {1'b0, 32'hA1B2C3D4}, st);
        drain();

        send(10'h10, 2'b11, {1'b1, 32'h0}, st);
        send(10'h10, 2'b00, {1'b0, 32'hDEADBEEF}, st);
        drain();

        tot = 0;
        for (int i = 0; i < 20; i++) begin
            send(10'((16 + i) * 4), 2'b00, {1'b0, pat(16 + i)}, st);
            tot += st;
        end
        check("stream_stalls", 32'(tot), 32'd0);
        drain();

        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            send(10'((40 + i) * 4), 2'b00, {1'b0, pat(40 + i)}, st);
            check("bp_accept_stall", 32'(st), 32'd0);
        end
        req_valid = 1; req_addr = 10'h10; conf = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_sram_en", 32'(sram_en), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 0;
        check("bp_full_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1;
        drain();
        @(negedge clk);
        check("bp_ready_again", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        rsp_ready = 0;
        for (int i = 0; i < 4; i++) send(10'((60 + i) * 4), 2'b00, {1'b0, pat(60 + i)}, st);
        rst = 1;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        expq.delete();
        rsp_ready = 1;
        @(negedge clk);
        check("postrst_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(10'h10, 2'b00, {1'b0, 32'hDEADBEEF}, st);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
